// File: rtl/simple_pkg.sv
// Shared types for the memory-side arbiters: FSM states, port IDs, the debug view
// and the text-segment address legality rule.
package simple_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_RESP} text_arb_state_t;
  typedef enum logic {PORT_F, PORT_D} text_arb_port_t;

  typedef struct packed {
    text_arb_state_t state;
    text_arb_port_t  owner;
    text_arb_port_t  last;
    logic [31:0]     address;
  } text_arb_dbg_t;

  // Word-aligned and inside [lo, hi], all unsigned 32-bit.
  function automatic logic text_addr_legal(input logic [31:0] address,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
    return (address[1:0] == 2'b00) && (address >= lo) && (address <= hi);
  endfunction

endpackage

// File: rtl/text_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. The pointer remembers the last granted port and only
// moves when the caller signals that the current grant was taken.
module rr_arbiter2
  import simple_pkg::*;
(
  input  logic           clock,
  input  logic           reset_n,
  input  logic           req_f,
  input  logic           req_d,
  input  logic           update,
  output logic           grant_valid,
  output text_arb_port_t grant,
  output text_arb_port_t last
);

  text_arb_port_t last_q;

  always_comb begin
    grant_valid = req_f | req_d;
    grant       = PORT_F;
    if (req_f && req_d) grant = (last_q == PORT_F) ? PORT_D : PORT_F;
    else if (req_d)     grant = PORT_D;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)                     last_q <= PORT_F;
    else if (update && grant_valid)   last_q <= grant;
  end

  assign last = last_q;

endmodule

// File: rtl/text_memory_arbiter.sv
// Shares the single-ported synchronous-read text memory between fetch (F) and
// data (D) requesters, rejecting misaligned or out-of-segment reads with an error.
`ifndef TEXT_BEGIN
`define TEXT_BEGIN 32'h0040_0000
`endif
`ifndef TEXT_END
`define TEXT_END 32'h0040_FFFC
`endif

module text_memory_arbiter
  import simple_pkg::*;
#(
  parameter logic [31:0] TEXT_BEGIN = `TEXT_BEGIN,
  parameter logic [31:0] TEXT_END   = `TEXT_END,
  parameter int          INDEX_W    = 14
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               f_req_valid,
  output logic               f_req_ready,
  input  logic [31:0]        f_req_address,
  input  logic               d_req_valid,
  output logic               d_req_ready,
  input  logic [31:0]        d_req_address,
  output logic               f_resp_valid,
  input  logic               f_resp_ready,
  output logic [31:0]        f_resp_data,
  output logic               f_resp_error,
  output logic               d_resp_valid,
  input  logic               d_resp_ready,
  output logic [31:0]        d_resp_data,
  output logic               d_resp_error,
  output logic [INDEX_W-1:0] mem_address,
  input  logic [31:0]        mem_q,
  output text_arb_dbg_t      dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Requesters hold valid/address until ready; responses hold valid/data/error until ready.

  text_arb_state_t state;
  text_arb_port_t  owner, grant, last;
  logic            grant_valid, accept, owner_ready, resp_error;
  logic [31:0]     addr_q, grant_addr, resp_data;

  rr_arbiter2 u_rr (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_f       (f_req_valid),
    .req_d       (d_req_valid),
    .update      (accept),
    .grant_valid (grant_valid),
    .grant       (grant),
    .last        (last)
  );

  assign accept      = (state == ARB_IDLE) && grant_valid;
  assign grant_addr  = (grant == PORT_D) ? d_req_address : f_req_address;
  assign f_req_ready = accept && (grant == PORT_F);
  assign d_req_ready = accept && (grant == PORT_D);
  assign owner_ready = (owner == PORT_F) ? f_resp_ready : d_resp_ready;

  // In IDLE the winner's address goes straight out so the memory samples it at the grant edge.
  assign mem_address = (state == ARB_IDLE) ? grant_addr[INDEX_W+1:2] : addr_q[INDEX_W+1:2];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      owner      <= PORT_F;
      addr_q     <= '0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            owner  <= grant;
            addr_q <= grant_addr;
            if (text_addr_legal(grant_addr, TEXT_BEGIN, TEXT_END)) begin
              state <= ARB_WAIT;
            end else begin
              resp_data  <= '0;
              resp_error <= 1'b1;
              state      <= ARB_RESP;
            end
          end
        end
        ARB_WAIT: begin
          resp_data  <= mem_q;
          resp_error <= 1'b0;
          state      <= ARB_RESP;
        end
        ARB_RESP: begin
          if (owner_ready) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign f_resp_valid = (state == ARB_RESP) && (owner == PORT_F);
  assign d_resp_valid = (state == ARB_RESP) && (owner == PORT_D);
  assign f_resp_data  = f_resp_valid ? resp_data : '0;
  assign d_resp_data  = d_resp_valid ? resp_data : '0;
  assign f_resp_error = f_resp_valid && resp_error;
  assign d_resp_error = d_resp_valid && resp_error;

  assign dbg = '{state: state, owner: owner, last: last, address: addr_q};

endmodule

// File: doc/text_memory_arbiter.md
# text_memory_arbiter

Shares the single-ported, synchronous-read program text memory between two read requesters: the instruction fetch unit (port F) and the data path (port D, for loads from the text segment). Requests use a valid/ready handshake, and the winner on conflict is chosen round-robin. The block checks that addresses are word-aligned and inside the text segment, and returns an error response instead of undefined data. It sits between the core and the `text_memory` macro, replacing direct address wiring to it.

## Interface
Parameters:
- `TEXT_BEGIN`, default `` `TEXT_BEGIN ``: lowest valid byte address.
- `TEXT_END`, default `` `TEXT_END ``: highest valid byte address (inclusive).
- `INDEX_W`, default 14: width of the memory word index.

Ports:
- `clock` in 1: sole clock. All state changes on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `f_req_valid` in 1, `f_req_ready` out 1, `f_req_address` in 32: fetch request.
- `d_req_valid` in 1, `d_req_ready` out 1, `d_req_address` in 32: data request.
- `f_resp_valid` out 1, `f_resp_ready` in 1, `f_resp_data` out 32, `f_resp_error` out 1: fetch response.
- `d_resp_valid` out 1, `d_resp_ready` in 1, `d_resp_data` out 32, `d_resp_error` out 1: data response.
- `mem_address` out `INDEX_W`: word index to `text_memory`. Equals `address[INDEX_W+1:2]` of the granted request.
- `mem_q` in 32: `text_memory` read data, valid one cycle after `mem_address` is sampled.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - `f_req_ready` and `d_req_ready` both follow the arbitration result: only the granted port sees ready=1.
  - If only one port is valid, that port is granted.
  - If both are valid, the port not granted last wins. After reset, F counts as "last granted", so D wins the first conflict.
- On grant:
  - The winner ID and the full address are latched, and the last-granted pointer is updated.
  - A request is legal when `address[1:0]==0` and `TEXT_BEGIN <= address <= TEXT_END`, both compared unsigned on 32 bits.
  - Legal request: go to WAIT.
  - Illegal request: go directly to RESP with error=1 and data=0. `text_memory` is not accessed for its result.
- WAIT: `mem_q` is captured into the response data register and error is set to 0. Go to RESP.
- RESP:
  - Only the owning port's `resp_valid` is 1. Data and error are stable until the handshake completes.
  - When the owner's `resp_ready`=1, go to IDLE.
  - Both `req_ready` signals are 0 in WAIT and RESP.
- `mem_address` is driven from the latched address in WAIT. In IDLE it is driven from the currently winning request's address. This lets the memory sample it at the grant edge.
- The non-owner port's `resp_data` is 0 and its `resp_error` is 0.
- A requester must hold its valid and address stable until it sees ready. The arbiter does not change the winner while a request is pending in IDLE.

## Timing
- Reset values: all `*_resp_valid`=0, `*_resp_error`=0, `*_resp_data`=0, FSM=IDLE, pointer=F, latched address=0.
  - `*_req_ready` are combinational from IDLE state and valids, so both are 0 after reset until a request arrives.
- Legal read: accepted at edge T, `mem_q` valid during T+1, `resp_valid`=1 from T+2. Latency is 2 cycles; throughput is one request per 3 cycles when `resp_ready` is held at 1.
- Illegal read: accepted at T, `resp_valid`=1 from T+1.
- Backpressure: `resp_valid` stays high indefinitely while `resp_ready`=0. No new requests are accepted during that time.
- A response handshake at edge E makes IDLE active in cycle E+1. A new grant can happen at edge E+1.
- Reset asserted in any state returns to IDLE at the next edge. Any pending response is discarded and never presented.
- Boundaries are inclusive: `TEXT_END` itself is legal, `TEXT_END+1` is illegal, and `TEXT_BEGIN-4` is illegal.

## Structure
- Shared package `simple_pkg` holds:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_RESP} text_arb_state_t`
  - `typedef enum logic {PORT_F, PORT_D} text_arb_port_t`
- One natural sub-module: `rr_arbiter2`, a 2-way round-robin grant with a pointer update input. It is reusable for the data memory.
- `text_memory` is instantiated by the parent, not inside this block.

## Test plan
- Reset, then F requests `TEXT_BEGIN+8` where memory holds `0x00A00093` -> `f_resp_valid` at T+2 with data `0x00A00093`, error 0. D outputs stay 0 throughout.
- F and D request in the same cycle, immediately after reset -> D granted first. F is granted at the first IDLE cycle after D's handshake. Pointer alternation is confirmed over 4 back-to-back conflicts: D, F, D, F.
- D requests `TEXT_END+1` -> `d_resp_valid` at T+1 with error 1 and data 0. F requests `TEXT_BEGIN+2` (misaligned) -> error 1.
- F response held with `f_resp_ready`=0 for 5 cycles while D is valid -> F data stable, `d_req_ready`=0 throughout. D is granted one cycle after F's handshake.
- `reset_n` pulsed low during WAIT -> no response is ever issued. FSM is in IDLE, all outputs are at reset values, and the next request completes normally.
- Request at `TEXT_END` (word-aligned) -> error 0 and data matches the last memory word.
